// File: rtl/dmem_lsu.sv
// Load/store unit: turns core byte/half/word requests into aligned word accesses on a
// single-port data memory, with read-modify-write for sub-word stores.
module dmem_lsu #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [AWIDTH-3:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_off;
    logic [AWIDTH-3:0]   r_waddr;
    logic [15:0]         r_wdata;

    logic                w_can_accept;
    logic                w_accept;
    logic                w_misaligned;
    logic [3:0]          w_lane_sel;
    logic [XLEN-1:0]     w_merged;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [XLEN-1:0]     w_load_data;
    logic                w_unused;

    assign w_unused = ^req_addr[XLEN-1:AWIDTH];

    // Reset low must block acceptance immediately, not just after the state register clears.
    assign w_can_accept = reset && (r_state != S_MERGE);
    assign req_ready    = w_can_accept;
    assign w_accept     = req_valid && w_can_accept;

    assign w_misaligned = (req_size == 2'b11)
                       || ((req_size == SZ_HALF) && req_addr[0])
                       || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Byte store hits one lane; half store hits the pair selected by the offset's upper bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_sel[gi] = (r_size == SZ_BYTE) ? (r_off == 2'(gi))
                                                        : (r_off[1] == 1'(gi / 2));
            assign w_merged[8*gi +: 8] = !w_lane_sel[gi] ? mem_rdata[8*gi +: 8]
                                       : (r_size == SZ_BYTE) ? r_wdata[7:0]
                                       : r_wdata[8*(gi % 2) +: 8];
        end
    endgenerate

    assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_load_data = mem_rdata;
        case (r_size)
            SZ_BYTE: w_load_data = {{(XLEN-8){~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{(XLEN-16){~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = S_IDLE;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;

        case (r_state)
            S_LOAD: begin
                rsp_valid = 1'b1;
                rsp_rdata = w_load_data;
            end
            S_DONE: rsp_valid = 1'b1;
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase

        if (r_state == S_MERGE) begin
            w_state_next = S_DONE;
            if (reset) begin
                mem_en    = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = r_waddr;
                mem_wdata = w_merged;
            end
        end else if (w_accept) begin
            if (w_misaligned) begin
                w_state_next = S_ERR;
            end else begin
                mem_en   = 1'b1;
                mem_addr = req_addr[AWIDTH-1:2];
                if (!req_wen) begin
                    w_state_next = S_LOAD;
                end else if (req_size == SZ_WORD) begin
                    mem_wen      = 1'b1;
                    mem_wdata    = req_wdata;
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_MERGE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_off      <= req_addr[1:0];
                r_waddr    <= req_addr[AWIDTH-1:2];
                r_wdata    <= req_wdata[15:0];
            end
        end
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the core's data port and the word-wide single-port data memory (rwmemory). Converts core byte/halfword/word load-store requests into aligned word accesses. Sub-word stores use a read-modify-write sequence. Loads return sign- or zero-extended data, and misaligned requests are flagged without touching memory.

Parameters:
XLEN, 32, data and core address width
AWIDTH, 10, byte-address width of data memory; word address is AWIDTH-2 bits

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept request this cycle
req_wen  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
req_addr  in  XLEN  byte address; bits above AWIDTH-1 ignored
req_wdata  in  XLEN  store data, right-justified
rsp_valid  out  1  single-cycle response pulse
rsp_rdata  out  XLEN  load result; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size request, valid with rsp_valid
mem_en  out  1  memory enable
mem_wen  out  1  memory write enable
mem_addr  out  AWIDTH-2  word address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data, valid 1 cycle after read enable

Behaviour:
- Reset (reset low, async):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready, mem_en and mem_wen are forced to 0 combinationally while reset is low.
- States: IDLE, LOAD, MERGE, DONE, ERR.
- req_ready=1 in IDLE, LOAD, DONE and ERR; 0 in MERGE. A request is accepted on a cycle with req_valid && req_ready.
- Response states: LOAD, DONE and ERR assert rsp_valid for exactly one cycle and accept a new request in that same cycle, giving back-to-back operation. With no new request, next state is IDLE.
- Accept cycle T, actions by request type:
  - Misaligned: size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11. No memory access. Next state ERR; at T+1 rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Load: at T drive mem_en=1, mem_wen=0, mem_addr=req_addr[AWIDTH-1:2]. Latch size, unsigned and addr[1:0]. Next state LOAD; at T+1 rsp_valid=1 with extracted data (latency 1).
  - Word store: at T drive mem_en=1, mem_wen=1, mem_wdata=req_wdata. Next state DONE; rsp_valid at T+1.
  - Sub-word store: at T issue a read as for a load and latch the request. At T+1 (MERGE) drive mem_en=1, mem_wen=1, same mem_addr, mem_wdata=mem_rdata with the target lane(s) replaced. Next state DONE; rsp_valid at T+2 (latency 2).
- Lane rules:
  - Byte lane = addr[1:0]; halfword lane = addr[1] (low half when 0). Little-endian.
  - Byte store replaces mem bits [8k+7:8k] with wdata[7:0]; half store replaces the 16-bit lane with wdata[15:0].
  - Load byte/half: lane shifted to bit 0, then sign- or zero-extended per latched unsigned. req_unsigned is ignored for word loads and all stores.
- Memory outputs are 0 when mem_en=0.
- Reset during MERGE aborts the write; memory is unchanged and no response is issued.
- rsp_rdata holds its value only while rsp_valid=1; it is 0 otherwise.

Test Plan:
1. Hold reset low 3 cycles with req_valid=1 -> req_ready=0, mem_en=0, rsp_valid=0, rsp_rdata=0.
2. SW 0xDEADBEEF @0x10, then LW @0x10 -> word 4 = 0xDEADBEEF; LW rsp_rdata=0xDEADBEEF exactly 1 cycle after accept, rsp_err=0.
3. From word 4 = 0xDEADBEEF:
   - LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
   - LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
   - All four issued back-to-back with no idle cycles.
4. SB 0x55 @0x11 -> word 4 = 0xDEAD55EF, rsp 2 cycles after accept, req_ready=0 in MERGE cycle. Then SH 0xAB1234 @0x12 -> word 4 = 0x123455EF.
5. LW @0x12, SH @0x13, size=11 @0x10 -> each gives rsp_err=1, rsp_rdata=0 at T+1; mem_en never asserted; word 4 unchanged.
6. SB 0x00 @0x10, with reset pulsed low during the MERGE cycle -> no write (word 4 unchanged), no rsp_valid; next LW @0x10 after reset returns the prior value.
